// File: rtl/mac_drain.sv
// Result drain for an N-PE MAC array. On done it snapshots every accumulator,
// streams the words out over a valid/ready port and reports their signed argmax.
module mac_drain_lane (
   input  logic        clk,
   input  logic        cap,
   input  logic [31:0] d,
   output logic [31:0] q
);
   // No reset here: a word is only read out after a capture has written it.
   always_ff @(posedge clk) if (cap) q <= d;
endmodule

module mac_drain #(
   parameter int N  = 10,
   parameter int IW = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N*32-1:0] p_all,
   input  logic            done,
   input  logic            out_ready,
   output logic            out_valid,
   output logic [31:0]     out_data,
   output logic [IW-1:0]   out_idx,
   output logic            out_last,
   output logic            busy,
   output logic [IW-1:0]   class_idx,
   output logic            class_valid,
   output logic            overrun
);
   typedef enum logic [1:0] {IDLE, SEND, FINISH} state_t;

   state_t             state;
   logic [IW-1:0]      cnt, nxt_idx, max_idx, best_idx;
   logic [31:0]        max_val, best_val;
   logic [N-1:0][31:0] snap;
   logic               cap, xfer, take;

   assign cap     = (state == IDLE) && done;
   assign xfer    = out_valid && out_ready;
   assign nxt_idx = cnt + 1'b1;

   // Index 0 seeds the running max; later words must be strictly greater,
   // so ties keep the lower index.
   assign take     = (cnt == '0) || ($signed(out_data) > $signed(max_val));
   assign best_val = take ? out_data : max_val;
   assign best_idx = take ? cnt : max_idx;

   for (genvar k = 0; k < N; k++) begin : g_lane
      mac_drain_lane u_lane (
         .clk (clk),
         .cap (cap),
         .d   (p_all[32*k +: 32]),
         .q   (snap[k])
      );
   end

   always_ff @(posedge clk) begin
      if (xfer) begin
         max_val <= best_val;
         max_idx <= best_idx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_idx     <= '0;
         out_last    <= 1'b0;
         busy        <= 1'b0;
         class_idx   <= '0;
         class_valid <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         class_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (done) begin
                  // Word 0 comes straight from p_all so it is valid next cycle.
                  state     <= SEND;
                  cnt       <= '0;
                  out_valid <= 1'b1;
                  out_data  <= p_all[31:0];
                  out_idx   <= '0;
                  out_last  <= 1'b0;
                  busy      <= 1'b1;
               end
            end
            SEND: begin
               if (done) overrun <= 1'b1;
               if (xfer) begin
                  if (out_last) begin
                     state       <= FINISH;
                     out_valid   <= 1'b0;
                     out_last    <= 1'b0;
                     busy        <= 1'b0;
                     class_idx   <= best_idx;
                     class_valid <= 1'b1;
                  end else begin
                     cnt      <= nxt_idx;
                     out_data <= snap[nxt_idx];
                     out_idx  <= nxt_idx;
                     out_last <= (nxt_idx == IW'(N-1));
                  end
               end
            end
            FINISH: begin
               if (done) overrun <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mac_drain.sv
// Directed + randomized bench for mac_drain; expected stream and argmax come
// from a plain array model of the snapshot.
module tb_mac_drain;
   localparam int N  = 10;
   localparam int IW = 4;

   typedef logic [31:0] vec_t [N];

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N*32-1:0] p_all;
   logic            done;
   logic            out_ready;
   logic            out_valid;
   logic [31:0]     out_data;
   logic [IW-1:0]   out_idx;
   logic            out_last;
   logic            busy;
   logic [IW-1:0]   class_idx;
   logic            class_valid;
   logic            overrun;

   int n_chk  = 0;
   int n_pass = 0;

   mac_drain #(.N(N), .IW(IW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .p_all       (p_all),
      .done        (done),
      .out_ready   (out_ready),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_idx     (out_idx),
      .out_last    (out_last),
      .busy        (busy),
      .class_idx   (class_idx),
      .class_valid (class_valid),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic int argmax(input vec_t p);
      int best = 0;
      for (int i = 1; i < N; i++)
         if ($signed(p[i]) > $signed(p[best])) best = i;
      return best;
   endfunction

   function automatic logic [N*32-1:0] pack(input vec_t p);
      logic [N*32-1:0] v;
      for (int i = 0; i < N; i++) v[32*i +: 32] = p[i];
      return v;
   endfunction

   function automatic logic [N*32-1:0] rand_bus();
      logic [N*32-1:0] v;
      for (int i = 0; i < N; i++) v[32*i +: 32] = $urandom;
      return v;
   endfunction

   // Called at a negedge with the DUT idle; returns at the negedge after FINISH.
   // mode: 0 ready always, 1 ready toggling 1/0, 2 random ready.
   // inj: transfer index at which a second done is injected (-1 = none).
   task automatic drain(input vec_t p, input int mode, input int inj, input logic exp_ovr);
      int k = 0;
      int cyc = 0;
      bit injected = 0;
      logic r;
      p_all = pack(p);
      done  = 1'b1;
      while (k < N && cyc < 200) begin
         @(negedge clk);
         cyc++;
         done  = 1'b0;
         p_all = rand_bus();
         chk("out_valid", out_valid, 1'b1);
         chk("busy", busy, 1'b1);
         chk("out_idx", out_idx, k);
         chk("out_data", out_data, p[k]);
         chk("out_last", out_last, (k == N-1));
         case (mode)
            0:       r = 1'b1;
            1:       r = (cyc % 2 == 1);
            default: r = 1'($urandom_range(0, 1));
         endcase
         out_ready = r;
         if (!injected && k == inj) begin
            injected = 1;
            done     = 1'b1;
         end
         if (r) k++;
      end
      chk("drain_count", k, N);
      if (mode == 0) chk("drain_cycles", cyc, N);
      @(negedge clk);
      done      = 1'b0;
      out_ready = 1'b0;
      chk("valid_after_last", out_valid, 1'b0);
      chk("busy_finish", busy, 1'b0);
      chk("class_valid", class_valid, 1'b1);
      chk("class_idx", class_idx, argmax(p));
      chk("overrun", overrun, exp_ovr);
      @(negedge clk);
      chk("class_valid_pulse", class_valid, 1'b0);
      chk("class_idx_hold", class_idx, argmax(p));
   endtask

   initial begin
      vec_t p;
      int   exp_cls;
      rst_n = 1'b0; done = 1'b0; out_ready = 1'b0; p_all = '0;
      #1;
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_last", out_last, 1'b0);
      chk("rst_data", out_data, 32'd0);
      chk("rst_idx", out_idx, 0);
      chk("rst_class", class_idx, 0);
      chk("rst_cvalid", class_valid, 1'b0);
      chk("rst_overrun", overrun, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // p_all wiggling without done must do nothing
      repeat (3) begin
         @(negedge clk);
         p_all = rand_bus();
         out_ready = 1'b1;
      end
      @(negedge clk);
      chk("idle_valid", out_valid, 1'b0);
      chk("idle_busy", busy, 1'b0);
      out_ready = 1'b0;

      // Ramp, ready held high
      for (int i = 0; i < N; i++) p[i] = 32'(i * 100 - 300);
      drain(p, 0, -1, 1'b0);

      // Tie at index 2/3 with toggling ready
      p = '{default: 32'd0};
      p[0] = 32'd5; p[1] = 32'hFFFF_FFF9; p[2] = 32'd42; p[3] = 32'd42;
      drain(p, 1, -1, 1'b0);

      // Most negative value must never win
      p = '{default: 32'hFFFF_FFFF};
      p[3] = 32'h8000_0000;
      drain(p, 0, -1, 1'b0);

      repeat (2) begin
         for (int i = 0; i < N; i++) p[i] = $urandom;
         drain(p, 2, -1, 1'b0);
      end

      // Second done mid-drain: ignored but flagged; next done accepted right after FINISH
      for (int i = 0; i < N; i++) p[i] = $urandom;
      drain(p, 0, 4, 1'b1);
      for (int i = 0; i < N; i++) p[i] = $urandom;
      drain(p, 2, -1, 1'b1);

      // Reset in the middle of a drain
      for (int i = 0; i < N; i++) p[i] = $urandom;
      p_all = pack(p);
      done = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      done = 1'b0;
      repeat (6) @(negedge clk);
      chk("pre_reset_idx", out_idx, 6);
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", out_valid, 1'b0);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_overrun", overrun, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("midrst_no_cvalid", class_valid, 1'b0);
         chk("midrst_class", class_idx, 0);
      end
      out_ready = 1'b0;
      for (int i = 0; i < N; i++) p[i] = $urandom;
      exp_cls = argmax(p);
      drain(p, 2, -1, 1'b0);
      chk("final_class", class_idx, exp_cls);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end
endmodule
